// File: rtl/world_bank.sv
// world_bank: double-buffered 2**ADDR_W square cell grid with a swap-time dump streamer.
// Define WORLD_SEED_EN to have reset load a glider into bank 0.
module world_bank #(
    parameter int ADDR_W = 6,
    parameter int GEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] row,
    input  logic [ADDR_W-1:0] col,
    input  logic              world_we,
    input  logic              world_out,
    output logic              world_in,
    input  logic              update_done,
    input  logic              dump_en,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_bit,
    output logic [ADDR_W-1:0] dump_row,
    output logic [ADDR_W-1:0] dump_col,
    output logic              dump_last,
    output logic [GEN_W-1:0]  gen_count,
    output logic              err_short,
    output logic              dump_overrun
);
    localparam int IW = 2 * ADDR_W;
    localparam int CW = IW + 1;
    localparam int N  = 1 << IW;

    typedef enum logic {RUN, DUMP} state_t;

    state_t            r_state, w_state_nxt;
    logic [N-1:0]      r_bank [2];
    logic [N-1:0]      w_seed;
    logic              r_rd_sel;
    logic [CW-1:0]     r_wr_count, w_wr_final;
    logic [IW-1:0]     r_dump_idx, w_dump_idx_nxt;
    logic              r_dump_valid, w_dump_valid_nxt;
    logic [GEN_W-1:0]  r_gen;
    logic              r_err_short, r_overrun;
    logic [IW-1:0]     w_cell;
    logic              w_last, w_xfer;

    assign w_cell     = {row, col};
    assign world_in   = r_bank[r_rd_sel][w_cell];
    assign w_wr_final = r_wr_count + CW'(world_we);
    assign w_last     = &r_dump_idx;
    assign w_xfer     = r_dump_valid & dump_ready;

`ifdef WORLD_SEED_EN
    always_comb begin
        w_seed = '0;
        w_seed[{ADDR_W'(1), ADDR_W'(2)}] = 1'b1;
        w_seed[{ADDR_W'(2), ADDR_W'(3)}] = 1'b1;
        w_seed[{ADDR_W'(3), ADDR_W'(1)}] = 1'b1;
        w_seed[{ADDR_W'(3), ADDR_W'(2)}] = 1'b1;
        w_seed[{ADDR_W'(3), ADDR_W'(3)}] = 1'b1;
    end
`else
    assign w_seed = '0;
`endif

    // The automaton only ever writes the bank that is not being read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank[0] <= w_seed;
            r_bank[1] <= '0;
        end else if (world_we) begin
            r_bank[~r_rd_sel][w_cell] <= world_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_rd_sel     <= 1'b0;
            r_wr_count   <= '0;
            r_gen        <= '0;
            r_err_short  <= 1'b0;
            r_overrun    <= 1'b0;
            r_dump_idx   <= '0;
            r_dump_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dump_idx   <= w_dump_idx_nxt;
            r_dump_valid <= w_dump_valid_nxt;
            r_overrun    <= r_overrun | (update_done && r_state == DUMP);
            if (update_done) begin
                r_rd_sel    <= ~r_rd_sel;
                r_gen       <= r_gen + GEN_W'(1);
                r_err_short <= r_err_short | (w_wr_final != CW'(N));
                r_wr_count  <= '0;
            end else begin
                r_wr_count <= w_wr_final;
            end
        end
    end

    // A swap during a dump restarts the stream on the freshly readable bank.
    always_comb begin
        w_state_nxt      = r_state;
        w_dump_idx_nxt   = r_dump_idx;
        w_dump_valid_nxt = r_dump_valid;
        if (r_state == RUN) begin
            if (update_done && dump_en) begin
                w_state_nxt      = DUMP;
                w_dump_idx_nxt   = '0;
                w_dump_valid_nxt = 1'b1;
            end
        end else if (update_done) begin
            w_dump_idx_nxt   = '0;
            w_dump_valid_nxt = 1'b1;
        end else if (w_xfer) begin
            w_dump_idx_nxt = r_dump_idx + IW'(1);
            if (w_last) begin
                w_state_nxt      = RUN;
                w_dump_valid_nxt = 1'b0;
            end
        end
    end

    assign dump_valid   = r_dump_valid;
    assign dump_row     = r_dump_idx[IW-1:ADDR_W];
    assign dump_col     = r_dump_idx[ADDR_W-1:0];
    assign dump_bit     = r_bank[r_rd_sel][r_dump_idx];
    assign dump_last    = r_dump_valid & w_last;
    assign gen_count    = r_gen;
    assign err_short    = r_err_short;
    assign dump_overrun = r_overrun;
endmodule
